// File: rtl/elpis_uart_rx.sv
// elpis_uart_rx: parametrised UART receiver with a first-word-fall-through
// receive FIFO and sticky framing / parity / overflow error flags.
//
// Ports:
//   clock      in   system clock, rising edge
//   resetb     in   asynchronous active-low reset
//   ser_rx     in   serial input, idle high, asynchronous to clock
//   rd_en      in   pop strobe (ignored when the FIFO is empty)
//   rd_data    out  head-of-FIFO character, valid while rd_valid
//   rd_valid   out  FIFO not empty
//   fifo_count out  occupied FIFO entries
//   frame_err  out  sticky: a stop bit was sampled low
//   parity_err out  sticky: parity mismatch on an otherwise good frame
//   overflow   out  sticky: character arrived while the FIFO was full
//   clear_err  in   clears the three sticky flags
module elpis_uart_rx #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          ser_rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    input  logic                          clear_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   COUNT_ONE = (AW + 1)'(1);
    localparam logic          PAR_ODD   = (PARITY == 1) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Parity bit the transmitter should have sent for a given character.
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] d,
                                             input logic odd);
        return odd ? ~(^d) : (^d);
    endfunction

    logic                 sync1_r;
    logic                 rx_sync_r;
    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [3:0]           idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 bad_par_r;

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr_r;
    logic [AW-1:0]        wr_ptr_r;
    logic [AW:0]          count_r;
    logic [DATA_BITS-1:0] rd_data_r;
    logic                 rd_valid_r;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 overflow_r;

    logic                 bit_done_s;
    logic                 push_s;
    logic                 frame_ev_s;
    logic                 parity_ev_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 wr_s;
    logic                 overflow_ev_s;
    logic [AW-1:0]        rd_ptr_nx_s;
    logic [AW:0]          count_nx_s;
    logic [DATA_BITS-1:0] head_nx_s;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            sync1_r   <= ser_rx;
            rx_sync_r <= sync1_r;
        end
    end

    assign bit_done_s = (cnt_r == BIT_LAST);

    // Stop-bit outcome decode: push, frame error or parity error.
    always_comb begin
        push_s      = 1'b0;
        frame_ev_s  = 1'b0;
        parity_ev_s = 1'b0;
        if ((state_r == ST_STOP) && bit_done_s) begin
            if (!rx_sync_r) begin
                frame_ev_s = 1'b1;
            end else if (idx_r == STOP_LAST) begin
                if (bad_par_r) begin
                    parity_ev_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end else begin
                push_s = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Receive FSM: start validation, data shift, parity check, stop bits, break wait.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            idx_r     <= 4'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            bad_par_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= {CW{1'b0}};
                    idx_r     <= 4'd0;
                    bad_par_r <= 1'b0;
                    state_r   <= rx_sync_r ? ST_IDLE : ST_START;
                end
                ST_START: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (cnt_r == HALF_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_done_s) begin
                        cnt_r   <= {CW{1'b0}};
                        shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        if (idx_r == DATA_LAST) begin
                            idx_r   <= 4'd0;
                            state_r <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_PARITY: begin
                    if (bit_done_s) begin
                        cnt_r     <= {CW{1'b0}};
                        bad_par_r <= (rx_sync_r != expected_parity(shift_r, PAR_ODD));
                        state_r   <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (bit_done_s) begin
                        cnt_r <= {CW{1'b0}};
                        if (!rx_sync_r) begin
                            state_r <= ST_BREAK;
                        end else if (idx_r == STOP_LAST) begin
                            state_r <= ST_IDLE;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    // A held-low line reports one frame error, not a stream of them.
                    state_r <= rx_sync_r ? ST_IDLE : ST_BREAK;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop_s         = rd_en && (count_r != {(AW + 1){1'b0}});
    assign full_s        = (count_r == DEPTH);
    assign wr_s          = push_s && (!full_s || pop_s);
    assign overflow_ev_s = push_s && full_s && !pop_s;
    assign rd_ptr_nx_s   = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

    // Next occupancy and next head; the head bypasses memory when it is the slot being written.
    always_comb begin
        count_nx_s = count_r;
        head_nx_s  = mem_r[rd_ptr_nx_s];
        case ({wr_s, pop_s})
            2'b10:   count_nx_s = count_r + COUNT_ONE;
            2'b01:   count_nx_s = count_r - COUNT_ONE;
            default: count_nx_s = count_r;
        endcase
        if (wr_s && (rd_ptr_nx_s == wr_ptr_r)) begin
            head_nx_s = shift_r;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s];
        end
    end

    // FIFO storage, pointers and registered head/valid/count.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_BITS{1'b0}};
            end
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW + 1){1'b0}};
            rd_data_r  <= {DATA_BITS{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r   <= rd_ptr_nx_s;
            count_r    <= count_nx_s;
            rd_data_r  <= head_nx_s;
            rd_valid_r <= (count_nx_s != {(AW + 1){1'b0}});
        end
    end

    // Sticky error flags; a fresh event outranks clear_err in the same cycle.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            frame_err_r  <= frame_ev_s    | (frame_err_r  & ~clear_err);
            parity_err_r <= parity_ev_s   | (parity_err_r & ~clear_err);
            overflow_r   <= overflow_ev_s | (overflow_r   & ~clear_err);
        end
    end

    assign rd_data    = rd_data_r;
    assign rd_valid   = rd_valid_r;
    assign fifo_count = count_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_elpis_uart_rx.sv
// Directed bench for elpis_uart_rx: four receiver instances with different
// frame formats / FIFO depths share a clock and reset; each has its own line.
module tb_elpis_uart_rx;

    localparam int CPB = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetb;
    logic ser     [4];
    logic rd_en   [4];
    logic clr     [4];
    logic valid   [4];
    logic fe      [4];
    logic pe      [4];
    logic ov      [4];

    logic [7:0] rd_a;  logic [4:0] cnt_a;
    logic [6:0] rd_b;  logic [4:0] cnt_b;
    logic [7:0] rd_c;  logic [2:0] cnt_c;
    logic [8:0] rd_d;  logic [4:0] cnt_d;

    int n_total = 0;
    int n_bad   = 0;

    elpis_uart_rx #(.CLKS_PER_BIT(CPB)) u_a (
        .clock(clock), .resetb(resetb), .ser_rx(ser[0]), .rd_en(rd_en[0]),
        .rd_data(rd_a), .rd_valid(valid[0]), .fifo_count(cnt_a),
        .frame_err(fe[0]), .parity_err(pe[0]), .overflow(ov[0]), .clear_err(clr[0]));

    elpis_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2)) u_b (
        .clock(clock), .resetb(resetb), .ser_rx(ser[1]), .rd_en(rd_en[1]),
        .rd_data(rd_b), .rd_valid(valid[1]), .fifo_count(cnt_b),
        .frame_err(fe[1]), .parity_err(pe[1]), .overflow(ov[1]), .clear_err(clr[1]));

    elpis_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_c (
        .clock(clock), .resetb(resetb), .ser_rx(ser[2]), .rd_en(rd_en[2]),
        .rd_data(rd_c), .rd_valid(valid[2]), .fifo_count(cnt_c),
        .frame_err(fe[2]), .parity_err(pe[2]), .overflow(ov[2]), .clear_err(clr[2]));

    elpis_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .STOP_BITS(2)) u_d (
        .clock(clock), .resetb(resetb), .ser_rx(ser[3]), .rd_en(rd_en[3]),
        .rd_data(rd_d), .rd_valid(valid[3]), .fifo_count(cnt_d),
        .frame_err(fe[3]), .parity_err(pe[3]), .overflow(ov[3]), .clear_err(clr[3]));

    function automatic logic [31:0] dat(input int u);
        case (u)
            0:       return {24'd0, rd_a};
            1:       return {25'd0, rd_b};
            2:       return {24'd0, rd_c};
            default: return {23'd0, rd_d};
        endcase
    endfunction

    function automatic logic [31:0] cnt(input int u);
        case (u)
            0:       return {27'd0, cnt_a};
            1:       return {27'd0, cnt_b};
            2:       return {29'd0, cnt_c};
            default: return {27'd0, cnt_d};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One frame starting at the current negedge; low_stop picks a stop bit to force low.
    task automatic send(input int u, input int nbits, input int data, input int par,
                        input bit flip, input int nstop, input int low_stop,
                        input logic end_level);
        logic p;
        ser[u] = 1'b0;
        tick(CPB);
        for (int i = 0; i < nbits; i++) begin
            ser[u] = data[i];
            tick(CPB);
        end
        if (par != 0) begin
            p = 1'b0;
            for (int i = 0; i < nbits; i++) p = p ^ data[i];
            if (par == 1) p = ~p;
            if (flip) p = ~p;
            ser[u] = p;
            tick(CPB);
        end
        for (int s = 0; s < nstop; s++) begin
            ser[u] = (s == low_stop) ? 1'b0 : 1'b1;
            tick(CPB);
        end
        ser[u] = end_level;
    endtask

    task automatic pop(input int u);
        rd_en[u] = 1'b1;
        tick(1);
        rd_en[u] = 1'b0;
    endtask

    task automatic clear(input int u);
        clr[u] = 1'b1;
        tick(1);
        clr[u] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetb = 1'b0;
        for (int u = 0; u < 4; u++) begin
            ser[u] = 1'b1; rd_en[u] = 1'b0; clr[u] = 1'b0;
        end
        tick(3);
        for (int u = 0; u < 4; u++) begin
            check("rst_count", cnt(u), 32'd0);
            check("rst_valid", {31'd0, valid[u]}, 32'd0);
            check("rst_data",  dat(u), 32'd0);
            check("rst_flags", {29'd0, fe[u], pe[u], ov[u]}, 32'd0);
        end
        resetb = 1'b1;
        tick(2);

        // 8N1 back-to-back 0x55, 0xA3 with exact push latency.
        fork
            begin
                send(0, 8, 'h55, 0, 1'b0, 1, -1, 1'b1);
                send(0, 8, 'hA3, 0, 1'b0, 1, -1, 1'b1);
            end
            begin
                tick(154);
                check("a_valid_before", {31'd0, valid[0]}, 32'd0);
                tick(1);
                check("a_valid_after", {31'd0, valid[0]}, 32'd1);
                check("a_count_1", cnt(0), 32'd1);
                check("a_head_first", dat(0), 32'h55);
                tick(159);
                check("a_count_before2", cnt(0), 32'd1);
                tick(1);
                check("a_count_2", cnt(0), 32'd2);
            end
        join
        check("a_pop1_data", dat(0), 32'h55);
        pop(0);
        check("a_pop2_data", dat(0), 32'hA3);
        check("a_pop_count", cnt(0), 32'd1);
        pop(0);
        check("a_empty_count", cnt(0), 32'd0);
        check("a_empty_valid", {31'd0, valid[0]}, 32'd0);
        check("a_flags", {29'd0, fe[0], pe[0], ov[0]}, 32'd0);

        // 7E1: good parity kept, flipped parity dropped and flagged.
        send(1, 7, 'h41, 2, 1'b0, 1, -1, 1'b1);
        tick(2);
        check("b_good_count", cnt(1), 32'd1);
        check("b_good_data", dat(1), 32'h41);
        check("b_good_perr", {31'd0, pe[1]}, 32'd0);
        send(1, 7, 'h41, 2, 1'b1, 1, -1, 1'b1);
        tick(2);
        check("b_bad_count", cnt(1), 32'd1);
        check("b_bad_perr", {31'd0, pe[1]}, 32'd1);
        check("b_bad_ferr", {31'd0, fe[1]}, 32'd0);
        clear(1);
        check("b_cleared", {31'd0, pe[1]}, 32'd0);
        pop(1);
        send(1, 7, 'h43, 2, 1'b0, 1, -1, 1'b1);
        tick(2);
        check("b_odd_weight_data", dat(1), 32'h43);
        check("b_odd_weight_perr", {31'd0, pe[1]}, 32'd0);
        pop(1);
        check("b_final_count", cnt(1), 32'd0);

        // Stop bit low, then the line held low for 100 bit times.
        send(0, 8, 'h7E, 0, 1'b0, 1, 0, 1'b0);
        tick(CPB * 10);
        check("c_ferr_set", {31'd0, fe[0]}, 32'd1);
        check("c_no_push", cnt(0), 32'd0);
        clear(0);
        tick(CPB * 90);
        ser[0] = 1'b1;
        tick(CPB * 2);
        check("c_single_ferr", {31'd0, fe[0]}, 32'd0);
        check("c_no_spurious", cnt(0), 32'd0);
        send(0, 8, 'h31, 0, 1'b0, 1, -1, 1'b1);
        tick(2);
        check("c_recover_count", cnt(0), 32'd1);
        check("c_recover_data", dat(0), 32'h31);
        pop(0);

        // Depth-4 FIFO: overflow on the fifth character.
        for (int v = 1; v <= 5; v++) send(2, 8, v, 0, 1'b0, 1, -1, 1'b1);
        tick(2);
        check("d_full_count", cnt(2), 32'd4);
        check("d_overflow", {31'd0, ov[2]}, 32'd1);
        for (int v = 1; v <= 4; v++) begin
            check("d_pop_data", dat(2), 32'(v));
            pop(2);
        end
        check("d_drained", cnt(2), 32'd0);
        clear(2);
        check("d_ov_cleared", {31'd0, ov[2]}, 32'd0);
        for (int v = 'h11; v <= 'h14; v++) send(2, 8, v, 0, 1'b0, 1, -1, 1'b1);
        check("d_refill_count", cnt(2), 32'd4);
        fork
            send(2, 8, 'h15, 0, 1'b0, 1, -1, 1'b1);
            begin
                tick(154);
                rd_en[2] = 1'b1;
                tick(1);
                rd_en[2] = 1'b0;
            end
        join
        tick(2);
        check("d_pushpop_count", cnt(2), 32'd4);
        check("d_pushpop_noov", {31'd0, ov[2]}, 32'd0);
        for (int v = 'h12; v <= 'h15; v++) begin
            check("d_pushpop_data", dat(2), 32'(v));
            pop(2);
        end

        // Short glitch on an idle line must not start a frame.
        ser[0] = 1'b0;
        tick(4);
        ser[0] = 1'b1;
        tick(40);
        check("e_glitch_count", cnt(0), 32'd0);
        check("e_glitch_flags", {29'd0, fe[0], pe[0], ov[0]}, 32'd0);

        // Reset mid-frame with a character already buffered.
        send(0, 8, 'h77, 0, 1'b0, 1, -1, 1'b1);
        tick(2);
        check("e_prefill", cnt(0), 32'd1);
        fork
            send(0, 8, 'hC3, 0, 1'b0, 1, -1, 1'b1);
            begin
                tick(60);
                resetb = 1'b0;
                tick(2);
                check("e_rst_count", cnt(0), 32'd0);
                check("e_rst_valid", {31'd0, valid[0]}, 32'd0);
                check("e_rst_data", dat(0), 32'd0);
                check("e_rst_flags", {29'd0, fe[0], pe[0], ov[0]}, 32'd0);
            end
        join
        tick(2);
        resetb = 1'b1;
        tick(4);
        send(0, 8, 'h5A, 0, 1'b0, 1, -1, 1'b1);
        tick(2);
        check("e_after_count", cnt(0), 32'd1);
        check("e_after_data", dat(0), 32'h5A);
        check("e_after_ferr", {31'd0, fe[0]}, 32'd0);
        pop(0);

        // 9 data bits, 2 stop bits.
        send(3, 9, 'h1FF, 0, 1'b0, 2, -1, 1'b1);
        send(3, 9, 'h100, 0, 1'b0, 2, -1, 1'b1);
        tick(2);
        check("f_count", cnt(3), 32'd2);
        check("f_data1", dat(3), 32'h1FF);
        pop(3);
        check("f_data2", dat(3), 32'h100);
        pop(3);
        check("f_ferr_clean", {31'd0, fe[3]}, 32'd0);
        send(3, 9, 'h0AA, 0, 1'b0, 2, 1, 1'b1);
        tick(2);
        check("f_ferr_second_stop", {31'd0, fe[3]}, 32'd1);
        check("f_dropped", cnt(3), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/elpis_uart_rx.md
# elpis_uart_rx

Parametrised UART receiver with a receive FIFO, the synthesizable successor to the fixed 8N1 bench-side UART monitor used by the Elpis print tests. It sits in the user project area on an mprj_io input, deserialises frames with configurable data width, parity and stop bits, buffers characters in a first-word-fall-through FIFO, and flags framing, parity and overflow errors. The core or Wishbone glue drains the FIFO through a single-cycle read strobe.

## Interface
- CLKS_PER_BIT, 4167: clock cycles per bit (4167 = 9600 baud at 40 MHz); legal range 8..65535.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries, power of two, 2..256.

- clock  in  1  system clock, rising edge.
- resetb  in  1  asynchronous active-low reset.
- ser_rx  in  1  serial input, idle high, asynchronous to clock.
- rd_en  in  1  pop strobe; ignored when FIFO empty.
- rd_data  out  DATA_BITS  head-of-FIFO character (valid while rd_valid).
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overflow  out  1  sticky: character received with FIFO full.
- clear_err  in  1  clears all three sticky flags.

## Operation
- ser_rx passes through a 2-FF synchroniser (both stages reset to 1); all logic uses the synchronised signal rx_s.
- Bit counter: $clog2(CLKS_PER_BIT) bits; bit index counter: 4 bits.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_s==0 -> START, clear bit counter.
- START: count to CLKS_PER_BIT/2-1 (mid start bit); rx_s==1 -> IDLE (glitch, nothing recorded); rx_s==0 -> DATA.
- DATA: sample rx_s every CLKS_PER_BIT cycles into shift register, LSB first; after DATA_BITS samples -> PARITY if PARITY!=0 else STOP.
- PARITY: one sample; compare with XOR of data (even: equal; odd: inverted); mismatch marks frame bad_parity.
- STOP: STOP_BITS samples, each CLKS_PER_BIT apart. Any low sample -> set frame_err, drop character, -> BREAK. All high: if bad_parity set parity_err and drop; else push into FIFO; -> IDLE.
- BREAK: wait for rx_s==1, then IDLE (a held-low line yields exactly one frame_err, no spurious frames).
- FIFO push when full with no pop that cycle: character dropped, overflow set. Push and pop in same cycle when full: both occur, no overflow, count unchanged. Push and pop when empty: push only takes effect on pop side next cycle (pop ignored).
- rd_en with rd_valid: rd_data advances to next entry next cycle, count decrements.
- clear_err clears flags; a new error event in the same cycle wins (flag stays 1).
- Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.

## Timing
- Reset values: rd_valid 0, fifo_count 0, rd_data 0, all error flags 0, FSM IDLE, synchroniser 1.
- Reset asserted mid-frame: frame abandoned, FIFO emptied, no flags; after release receiver resumes at IDLE (a still-low line re-enters START).
- Falling edge on ser_rx to IDLE->START: 3 clocks (2 sync + 1 register).
- First data sample: CLKS_PER_BIT/2 + CLKS_PER_BIT cycles after START entry; subsequent samples every CLKS_PER_BIT.
- Final stop sample to rd_valid/fifo_count update: 1 cycle; error flags assert same 1-cycle latency.
- Back-to-back frames: next start bit may begin immediately after the (last) stop-bit midpoint; receiver is in IDLE in time.
- rd_en -> rd_data/fifo_count update: 1 cycle.

## Test plan
- CLKS_PER_BIT=16, 8N1: send 0x55 then 0xA3 back-to-back -> rd_valid rises 1 cycle after each stop sample, fifo_count 2, pops return 0x55 then 0xA3, no flags.
- PARITY=2, DATA_BITS=7: send 0x41 with correct parity -> pushed; send 0x41 with flipped parity -> not pushed, parity_err=1; clear_err -> 0.
- Stop bit low on 0x7E, then line held low 100 bit times -> exactly one frame_err, fifo_count 0, next valid 0x31 received after line returns high.
- FIFO_DEPTH=4: send 5 chars 0x01..0x05 without reads -> count 4, overflow=1, pops yield 0x01..0x04; then fill to full and pop on the push cycle -> count stays 4, no overflow.
- 4-cycle low glitch on idle line -> no frame, no flags; resetb pulsed mid-DATA of 0xC3 -> all outputs at reset values, following 0x5A received correctly.
- STOP_BITS=2, DATA_BITS=9: send 0x1FF and 0x100 -> both received intact, second stop bit low on a third frame -> frame_err.
